// File: rtl/digout_sequencer_multi_pkg.sv
// Shared definitions for the multi-channel digital-output pulse sequencer:
// register map, configuration bit positions and the channel state type.
package digout_seq_pkg;

  localparam logic [2:0] ADDR_CFG       = 3'd0;
  localparam logic [2:0] ADDR_NPULSES   = 3'd1;
  localparam logic [2:0] ADDR_EV_START  = 3'd2;
  localparam logic [2:0] ADDR_EV_END    = 3'd3;
  localparam logic [2:0] ADDR_EV_REPEAT = 3'd4;
  localparam logic [2:0] ADDR_EV_FINAL  = 3'd5;

  // Trigger source select occupies the low bits of the cfg word.
  localparam int CFG_EDGE = 5;
  localparam int CFG_POL  = 6;
  localparam int CFG_EN   = 7;
  localparam int CFG_CONT = 8;
  localparam int CFG_INV  = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chState_e;

endpackage

// File: rtl/digout_sequencer_multi_if.sv
// Programming bus of the sequencer: one-cycle write strobe with module,
// channel, register select and data.
interface digout_sequencer_multi_if;

  logic        prog_we;
  logic [4:0]  prog_module;
  logic [4:0]  prog_channel;
  logic [2:0]  prog_address;
  logic [15:0] prog_word;

  modport master (
    output prog_we, prog_module, prog_channel, prog_address, prog_word
  );

  modport slave (
    input prog_we, prog_module, prog_channel, prog_address, prog_word
  );

endinterface

// File: rtl/digout_sequencer_multi_channel.sv
// One sequencer channel: its configuration registers, IDLE/RUN state machine,
// event and pulse counters, all advancing only on sample ticks.
module digout_seq_channel
  import digout_seq_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PULSE_W = 8,
  parameter int TRIG_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic [TRIG_W-1:0] triggers_i,
  input  logic              shutdown_i,
  input  logic              rst_seq_i,
  input  logic              we_i,
  input  logic [2:0]        addr_i,
  input  logic [15:0]       wdata_i,
  output logic              digout_o,
  output logic              enabled_o,
  output logic              busy_o
);

  localparam int TRIG_SEL_W = $clog2(TRIG_W);

  logic [TRIG_SEL_W-1:0] src_q;
  logic                  edgeMode_q, pol_q, en_q, cont_q, inv_q;
  logic [PULSE_W-1:0]    npulses_q;
  logic [CNT_W-1:0]      evStart_q, evEnd_q, evRepeat_q, evFinal_q;

  chState_e           state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PULSE_W-1:0] pcnt_q, pcnt_d;
  logic               raw_q, raw_d;
  logic               armed_q, armed_d;

  logic               trig;
  logic               doRun;
  logic [CNT_W-1:0]   runCnt;
  logic [PULSE_W-1:0] runPcnt;
  logic               runRaw;

  assign trig = triggers_i[src_q] ^ pol_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q      <= '0;
      edgeMode_q <= 1'b0;
      pol_q      <= 1'b0;
      en_q       <= 1'b0;
      cont_q     <= 1'b0;
      inv_q      <= 1'b0;
      npulses_q  <= '0;
      evStart_q  <= '0;
      evEnd_q    <= '0;
      evRepeat_q <= '0;
      evFinal_q  <= '0;
    end else if (we_i) begin
      case (addr_i)
        ADDR_CFG: begin
          src_q      <= wdata_i[TRIG_SEL_W-1:0];
          edgeMode_q <= wdata_i[CFG_EDGE];
          pol_q      <= wdata_i[CFG_POL];
          en_q       <= wdata_i[CFG_EN];
          cont_q     <= wdata_i[CFG_CONT];
          inv_q      <= wdata_i[CFG_INV];
        end
        ADDR_NPULSES:   npulses_q  <= wdata_i[PULSE_W-1:0];
        ADDR_EV_START:  evStart_q  <= wdata_i[CNT_W-1:0];
        ADDR_EV_END:    evEnd_q    <= wdata_i[CNT_W-1:0];
        ADDR_EV_REPEAT: evRepeat_q <= wdata_i[CNT_W-1:0];
        ADDR_EV_FINAL:  evFinal_q  <= wdata_i[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      raw_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      raw_q   <= raw_d;
      armed_q <= armed_d;
    end
  end

  // A triggering IDLE tick is evaluated as a RUN tick starting from cnt=0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    raw_d   = raw_q;
    armed_d = armed_q;
    doRun   = 1'b0;
    runCnt  = cnt_q;
    runPcnt = pcnt_q;
    runRaw  = raw_q;
    if (tick_i) begin
      if (rst_seq_i) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        pcnt_d  = '0;
        raw_d   = 1'b0;
        armed_d = 1'b0;
      end else if (state_q == ST_IDLE) begin
        cnt_d  = '0;
        pcnt_d = npulses_q;
        raw_d  = 1'b0;
        if (edgeMode_q && !trig) armed_d = 1'b1;
        if (en_q && trig && (!edgeMode_q || armed_q)) begin
          doRun   = 1'b1;
          runCnt  = '0;
          runPcnt = npulses_q;
          runRaw  = 1'b0;
        end
      end else if (!en_q) begin
        state_d = ST_IDLE;
        raw_d   = 1'b0;
      end else begin
        doRun = 1'b1;
      end

      if (doRun) begin
        state_d = ST_RUN;
        raw_d   = runRaw;
        if (runCnt == evStart_q) raw_d = 1'b1;
        if (runCnt == evEnd_q)   raw_d = 1'b0;
        if (shutdown_i)          raw_d = 1'b0;
        if (runCnt == evRepeat_q && runPcnt != '0) begin
          cnt_d  = evStart_q;
          pcnt_d = runPcnt - PULSE_W'(1);
        end else if (runCnt == evFinal_q && runPcnt == '0) begin
          if (cont_q && en_q && trig) begin
            cnt_d  = '0;
            pcnt_d = npulses_q;
          end else begin
            state_d = ST_IDLE;
            armed_d = !edgeMode_q;
          end
        end else begin
          cnt_d = runCnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    digout_o  = raw_q ^ inv_q;
    busy_o    = (state_q == ST_RUN);
    enabled_o = en_q;
  end

endmodule

// File: rtl/digout_sequencer_multi.sv
// Multi-channel digital-output pulse sequencer: decodes programming writes
// and gathers the per-channel outputs into buses.
module digout_sequencer_multi
  import digout_seq_pkg::*;
#(
  parameter int MODULE  = 0,
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 16,
  parameter int PULSE_W = 8,
  parameter int TRIG_W  = 32
) (
  input  logic                 dataclk,
  input  logic                 reset_n,
  input  logic                 sample_tick,
  input  logic [TRIG_W-1:0]    triggers,
  input  logic                 shutdown,
  input  logic                 reset_sequencer,
  digout_sequencer_multi_if.slave prog,
  output logic [NUM_CH-1:0]    digout,
  output logic [NUM_CH-1:0]    digout_enabled,
  output logic [NUM_CH-1:0]    busy
);

  localparam logic [4:0] MODULE_ID = 5'(MODULE);

  logic              progHit;
  logic [NUM_CH-1:0] chanWe;

  // The full 5-bit channel field is compared so out-of-range writes never alias.
  assign progHit = prog.prog_we && (prog.prog_module == MODULE_ID)
                   && ({27'd0, prog.prog_channel} < 32'(NUM_CH));

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    assign chanWe[g] = progHit && (prog.prog_channel == 5'(g));

    digout_seq_channel #(
      .CNT_W   (CNT_W),
      .PULSE_W (PULSE_W),
      .TRIG_W  (TRIG_W)
    ) uChannel (
      .clk_i      (dataclk),
      .rst_ni     (reset_n),
      .tick_i     (sample_tick),
      .triggers_i (triggers),
      .shutdown_i (shutdown),
      .rst_seq_i  (reset_sequencer),
      .we_i       (chanWe[g]),
      .addr_i     (prog.prog_address),
      .wdata_i    (prog.prog_word),
      .digout_o   (digout[g]),
      .enabled_o  (digout_enabled[g]),
      .busy_o     (busy[g])
    );
  end

endmodule

// File: tb/tb_digout_sequencer_multi.sv
// Directed self-checking bench for digout_sequencer_multi with four channels,
// module ID 3 and an 8-bit trigger bus.
module tb_digout_sequencer_multi;
  import digout_seq_pkg::*;

  localparam int         NUM_CH = 4;
  localparam int         TRIG_W = 8;
  localparam logic [4:0] MOD_ID = 5'd3;

  logic              dataclk = 1'b0;
  logic              reset_n;
  logic              sample_tick;
  logic [TRIG_W-1:0] triggers;
  logic              shutdown;
  logic              reset_sequencer;
  logic [NUM_CH-1:0] digout;
  logic [NUM_CH-1:0] digout_enabled;
  logic [NUM_CH-1:0] busy;

  int nVec = 0;
  int nMis = 0;

  digout_sequencer_multi_if progIf ();

  digout_sequencer_multi #(
    .MODULE  (3),
    .NUM_CH  (NUM_CH),
    .CNT_W   (16),
    .PULSE_W (8),
    .TRIG_W  (TRIG_W)
  ) dut (
    .dataclk         (dataclk),
    .reset_n         (reset_n),
    .sample_tick     (sample_tick),
    .triggers        (triggers),
    .shutdown        (shutdown),
    .reset_sequencer (reset_sequencer),
    .prog            (progIf),
    .digout          (digout),
    .digout_enabled  (digout_enabled),
    .busy            (busy)
  );

  always #5 dataclk = ~dataclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One sample tick; outputs are then looked at on the following falling edge.
  task automatic applyStimulus();
    @(negedge dataclk);
    sample_tick = 1'b1;
    @(negedge dataclk);
    sample_tick = 1'b0;
  endtask

  task automatic progWrite(input logic [4:0] m, input logic [4:0] c,
                           input logic [2:0] a, input logic [15:0] w);
    @(negedge dataclk);
    progIf.prog_we      = 1'b1;
    progIf.prog_module  = m;
    progIf.prog_channel = c;
    progIf.prog_address = a;
    progIf.prog_word    = w;
    @(negedge dataclk);
    progIf.prog_we      = 1'b0;
  endtask

  task automatic setupChannel(input int ch, input logic [15:0] evS, input logic [15:0] evE,
                              input logic [15:0] evR, input logic [15:0] evF,
                              input logic [15:0] np, input logic [15:0] cfg);
    progWrite(MOD_ID, 5'(ch), ADDR_EV_START,  evS);
    progWrite(MOD_ID, 5'(ch), ADDR_EV_END,    evE);
    progWrite(MOD_ID, 5'(ch), ADDR_EV_REPEAT, evR);
    progWrite(MOD_ID, 5'(ch), ADDR_EV_FINAL,  evF);
    progWrite(MOD_ID, 5'(ch), ADDR_NPULSES,   np);
    progWrite(MOD_ID, 5'(ch), ADDR_CFG,       cfg);
  endtask

  // Bit i of each mask is the expected pin/busy value after tick i.
  task automatic runTicks(input int ch, input int n, input logic [31:0] digMask,
                          input logic [31:0] busyMask, input int dropAfter);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      checkOutput($sformatf("ch%0d digout t%0d", ch, i), 32'(digout[ch]), 32'(digMask[i]));
      checkOutput($sformatf("ch%0d busy t%0d", ch, i), 32'(busy[ch]), 32'(busyMask[i]));
      if (i == dropAfter) triggers[ch] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n             = 1'b0;
    sample_tick         = 1'b0;
    shutdown            = 1'b0;
    reset_sequencer     = 1'b0;
    triggers            = 8'b0000_0100;
    progIf.prog_we      = 1'b0;
    progIf.prog_module  = '0;
    progIf.prog_channel = '0;
    progIf.prog_address = '0;
    progIf.prog_word    = '0;
    repeat (3) @(negedge dataclk);
    checkOutput("reset digout", 32'(digout), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset enabled", 32'(digout_enabled), 32'h0);
    reset_n = 1'b1;

    // Level trigger, single pulse high after ticks 2-3, busy through tick 8
    setupChannel(0, 16'd2, 16'd4, 16'd0, 16'd9, 16'd0, 16'h0080);
    checkOutput("enabled after cfg", 32'(digout_enabled), 32'h1);
    triggers[0] = 1'b1;
    runTicks(0, 10, 32'h00C, 32'h1FF, 0);
    runTicks(0, 1, 32'h0, 32'h0, -1);

    // Three pulses via repeat, then back to IDLE
    setupChannel(1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd2, 16'h0081);
    triggers[1] = 1'b1;
    runTicks(1, 12, 32'h092, 32'h7FF, 0);

    // Edge mode: trig high since reset must not start; low then high does
    setupChannel(2, 16'd0, 16'd1, 16'd0, 16'd2, 16'd0, 16'h00A2);
    runTicks(2, 3, 32'h0, 32'h0, -1);
    triggers[2] = 1'b0;
    runTicks(2, 1, 32'h0, 32'h0, -1);
    triggers[2] = 1'b1;
    runTicks(2, 3, 32'h1, 32'h3, -1);
    runTicks(2, 3, 32'h0, 32'h0, -1);

    // Continuous retrigger, then trig dropped after tick 6
    setupChannel(3, 16'd0, 16'd1, 16'd0, 16'd2, 16'd0, 16'h0183);
    triggers[3] = 1'b1;
    runTicks(3, 10, 32'h049, 32'h0FF, 6);

    // Inverted output with shutdown from tick 3 onward
    progWrite(MOD_ID, 5'd0, ADDR_CFG, 16'h0280);
    checkOutput("inv idle pin", 32'(digout[0]), 32'h1);
    triggers[0] = 1'b1;
    runTicks(0, 3, 32'h3, 32'h7, 0);
    shutdown = 1'b1;
    runTicks(0, 7, 32'h7F, 32'h3F, -1);
    shutdown = 1'b0;

    // Asynchronous reset in the middle of a run
    triggers[0] = 1'b1;
    runTicks(0, 3, 32'h3, 32'h7, 0);
    @(negedge dataclk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async rst digout", 32'(digout), 32'h0);
    checkOutput("async rst busy", 32'(busy), 32'h0);
    checkOutput("async rst enabled", 32'(digout_enabled), 32'h0);
    @(negedge dataclk);
    reset_n = 1'b1;

    // Writes to another module or an absent channel are ignored
    progWrite(5'd4, 5'd0, ADDR_CFG, 16'h0080);
    checkOutput("wrong module", 32'(digout_enabled), 32'h0);
    progWrite(MOD_ID, 5'd4, ADDR_CFG, 16'h0080);
    checkOutput("channel 4", 32'(digout_enabled), 32'h0);
    progWrite(MOD_ID, 5'd31, ADDR_CFG, 16'h0080);
    checkOutput("channel 31", 32'(digout_enabled), 32'h0);
    progWrite(MOD_ID, 5'd0, ADDR_CFG, 16'h0080);
    checkOutput("valid write", 32'(digout_enabled), 32'h1);

    // Enable written on the same cycle as a tick: that tick still sees en=0
    setupChannel(1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'h0001);
    triggers[1] = 1'b1;
    @(negedge dataclk);
    sample_tick         = 1'b1;
    progIf.prog_we      = 1'b1;
    progIf.prog_module  = MOD_ID;
    progIf.prog_channel = 5'd1;
    progIf.prog_address = ADDR_CFG;
    progIf.prog_word    = 16'h0081;
    @(negedge dataclk);
    sample_tick    = 1'b0;
    progIf.prog_we = 1'b0;
    checkOutput("tick-coincident busy", 32'(busy[1]), 32'h0);
    checkOutput("tick-coincident enabled", 32'(digout_enabled), 32'h3);
    runTicks(1, 2, 32'h1, 32'h1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
